// File: rtl/kgp_risc_control_fsm_pkg.sv
// KGP-RISC control sequencer: opcodes, state encodings, pc_src codes
// and the opcode classifier shared by the sequencer files.
package kgp_risc_control_fsm_pkg;

  localparam logic [5:0] OP_ALU_R = 6'h00;
  localparam logic [5:0] OP_ALU_I = 6'h01;
  localparam logic [5:0] OP_LW    = 6'h02;
  localparam logic [5:0] OP_SW    = 6'h03;
  localparam logic [5:0] OP_B     = 6'h04;
  localparam logic [5:0] OP_BR    = 6'h05;
  localparam logic [5:0] OP_BL    = 6'h06;
  localparam logic [5:0] OP_BLTZ  = 6'h08;
  localparam logic [5:0] OP_BZ    = 6'h09;
  localparam logic [5:0] OP_BNZ   = 6'h0A;
  localparam logic [5:0] OP_BCY   = 6'h0B;
  localparam logic [5:0] OP_BNCY  = 6'h0C;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_LABEL = 2'd1;
  localparam logic [1:0] PC_RS    = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_MEM,
    C_BR,
    C_HALT,
    C_BAD
  } op_class_t;

  function automatic op_class_t op_class(logic [5:0] op);
    op_class_t c;
    case (op)
      OP_ALU_R, OP_ALU_I: c = C_ALU;
      OP_LW, OP_SW:       c = C_MEM;
      OP_B, OP_BR, OP_BL,
      OP_BLTZ, OP_BZ, OP_BNZ,
      OP_BCY, OP_BNCY:    c = C_BR;
      OP_HALT:            c = C_HALT;
      default:            c = C_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/kgp_risc_control_fsm_if.sv
// Sequencer <-> datapath bundle; master is the sequencer side.
// illegal exists only when KGP_ILLEGAL_TRAP_EN is defined.
interface kgp_risc_control_fsm_if #(
  parameter int RETIRE_W = 32
);
  logic                start;
  logic [5:0]          opcode;
  logic                zero_flag;
  logic                sign_flag;
  logic                carry_flag;
  logic                pc_write;
  logic [1:0]          pc_src;
  logic                ir_write;
  logic                reg_write;
  logic                link_wr;
  logic                alu_src_imm;
  logic                flags_write;
  logic                mem_read;
  logic                mem_write;
  logic                wb_sel;
  logic                busy;
  logic                halted;
  logic [RETIRE_W-1:0] retired;
`ifdef KGP_ILLEGAL_TRAP_EN
  logic                illegal;
`endif

  modport master (
    input  start, opcode,
    input  zero_flag, sign_flag, carry_flag,
    output pc_write, pc_src, ir_write,
    output reg_write, link_wr,
    output alu_src_imm, flags_write,
    output mem_read, mem_write, wb_sel,
    output busy, halted, retired
`ifdef KGP_ILLEGAL_TRAP_EN
    , output illegal
`endif
  );

  modport slave (
    output start, opcode,
    output zero_flag, sign_flag, carry_flag,
    input  pc_write, pc_src, ir_write,
    input  reg_write, link_wr,
    input  alu_src_imm, flags_write,
    input  mem_read, mem_write, wb_sel,
    input  busy, halted, retired
`ifdef KGP_ILLEGAL_TRAP_EN
    , input illegal
`endif
  );

endinterface

// File: rtl/kgp_risc_branch_eval.sv
// Branch resolution: opcode + flags -> taken.
// Unconditional branches are always taken; non-branches never.
module kgp_risc_branch_eval
  import kgp_risc_control_fsm_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       zero_flag,
  input  logic       sign_flag,
  input  logic       carry_flag,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      opcode == OP_B,
      opcode == OP_BR,
      opcode == OP_BL:   taken = 1'b1;
      opcode == OP_BLTZ: taken = sign_flag;
      opcode == OP_BZ:   taken = zero_flag;
      opcode == OP_BNZ:  taken = ~zero_flag;
      opcode == OP_BCY:  taken = carry_flag;
      opcode == OP_BNCY: taken = ~carry_flag;
      default:           taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/kgp_risc_control_fsm.sv
// KGP-RISC multi-cycle sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT).
// Define KGP_ILLEGAL_TRAP_EN to trap unlisted opcodes into HALT.
module kgp_risc_control_fsm
  import kgp_risc_control_fsm_pkg::*;
#(
  parameter int MEM_LAT  = 1,
  parameter int RETIRE_W = 32
) (
  input  logic clk,
  input  logic rst,
  kgp_risc_control_fsm_if.master bus
);

  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

  state_t              state;
  logic [2:0]          wait_cnt;
  logic [RETIRE_W-1:0] retired_q;
  op_class_t           cls;
  logic                taken;
  logic                is_lw;
  logic                wait_last;
  logic                retire;

  assign cls       = op_class(bus.opcode);
  assign is_lw     = (bus.opcode == OP_LW);
  assign wait_last = (wait_cnt == LAST);

  kgp_risc_branch_eval u_branch_eval (
    .opcode     (bus.opcode),
    .zero_flag  (bus.zero_flag),
    .sign_flag  (bus.sign_flag),
    .carry_flag (bus.carry_flag),
    .taken      (taken)
  );

  always_comb begin
    retire = 1'b0;
    unique case (1'b1)
      state == S_EXEC:   retire = (cls == C_BR);
      state == S_MEM:    retire = wait_last & ~is_lw;
      state == S_WB:     retire = 1'b1;
`ifndef KGP_ILLEGAL_TRAP_EN
      state == S_DECODE: retire = (cls == C_BAD);
`endif
      default:           retire = 1'b0;
    endcase
  end

`ifdef KGP_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign bus.illegal = illegal_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      retired_q <= '0;
`ifdef KGP_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      if (retire) retired_q <= retired_q + 1'b1;
      unique case (state)
        S_IDLE: if (bus.start) state <= S_FETCH;
        S_FETCH: begin
          if (wait_last) begin
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        S_DECODE: begin
          unique case (cls)
            C_HALT: state <= S_HALT;
`ifdef KGP_ILLEGAL_TRAP_EN
            C_BAD: begin
              state     <= S_HALT;
              illegal_q <= 1'b1;
            end
`else
            C_BAD:  state <= S_FETCH;
`endif
            default: state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          unique case (cls)
            C_ALU:   state <= S_WB;
            C_MEM:   state <= S_MEM;
            default: state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (wait_last) begin
            wait_cnt <= '0;
            state    <= is_lw ? S_WB : S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.retired = retired_q;
  assign bus.busy    = (state != S_IDLE) && (state != S_HALT);
  assign bus.halted  = (state == S_HALT);

  // Strobes decode from state and the opcode held by the decoder.
  always_comb begin
    bus.pc_write    = 1'b0;
    bus.pc_src      = PC_PLUS4;
    bus.ir_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.link_wr     = 1'b0;
    bus.alu_src_imm = 1'b0;
    bus.flags_write = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.wb_sel      = 1'b0;
    unique case (state)
      S_FETCH: begin
        bus.ir_write = wait_last;
        bus.pc_write = wait_last;
      end
      S_EXEC: begin
        unique case (cls)
          C_ALU: begin
            bus.flags_write = 1'b1;
            bus.alu_src_imm = (bus.opcode == OP_ALU_I);
          end
          C_MEM: bus.alu_src_imm = 1'b1;
          C_BR: begin
            bus.pc_write  = taken;
            bus.pc_src    = (bus.opcode == OP_BR) ? PC_RS : PC_LABEL;
            bus.reg_write = (bus.opcode == OP_BL);
            bus.link_wr   = (bus.opcode == OP_BL);
          end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.mem_read  = is_lw;
        bus.mem_write = ~is_lw & (wait_cnt == 3'd0);
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        bus.wb_sel    = is_lw;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_kgp_risc_control_fsm.sv
// Bench for kgp_risc_control_fsm: per-cycle strobe scoreboard, retire
// count with wrap, reset abort, HALT and illegal-opcode handling.
module tb_kgp_risc_control_fsm;
  import kgp_risc_control_fsm_pkg::*;

  localparam int ML = 2;
  localparam int RW = 4;

  localparam logic [12:0] PCW  = 13'h1000;
  localparam logic [12:0] PCS1 = 13'h0400;
  localparam logic [12:0] PCS2 = 13'h0800;
  localparam logic [12:0] IRW  = 13'h0200;
  localparam logic [12:0] RGW  = 13'h0100;
  localparam logic [12:0] LNK  = 13'h0080;
  localparam logic [12:0] IMM  = 13'h0040;
  localparam logic [12:0] FLW  = 13'h0020;
  localparam logic [12:0] MRD  = 13'h0010;
  localparam logic [12:0] MWR  = 13'h0008;
  localparam logic [12:0] WBS  = 13'h0004;
  localparam logic [12:0] BSY  = 13'h0002;
  localparam logic [12:0] HLT  = 13'h0001;

  typedef struct {
    logic [5:0] op;
    bit         z;
    bit         s;
    bit         c;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  kgp_risc_control_fsm_if #(.RETIRE_W(RW)) bus ();

  kgp_risc_control_fsm #(
    .MEM_LAT  (ML),
    .RETIRE_W (RW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          nvec = 0;
  int          nerr = 0;
  int          exp_ret = 0;
  logic [12:0] q[$];
  int          ret_q[$];

  stim_t tbl [18] = '{
    '{6'h00, 0, 0, 0}, '{6'h01, 0, 0, 0}, '{6'h02, 0, 0, 0},
    '{6'h03, 0, 0, 0}, '{6'h04, 0, 0, 0}, '{6'h05, 0, 0, 0},
    '{6'h06, 0, 0, 0}, '{6'h09, 1, 0, 0}, '{6'h09, 0, 0, 0},
    '{6'h0A, 0, 0, 0}, '{6'h0A, 1, 0, 0}, '{6'h08, 0, 1, 0},
    '{6'h08, 0, 0, 0}, '{6'h0B, 0, 0, 1}, '{6'h0C, 0, 0, 0},
    '{6'h0C, 0, 0, 1}, '{6'h02, 1, 1, 1}, '{6'h00, 0, 1, 0}
  };

  function automatic logic [12:0] obs();
    return {bus.pc_write, bus.pc_src, bus.ir_write,
            bus.reg_write, bus.link_wr, bus.alu_src_imm,
            bus.flags_write, bus.mem_read, bus.mem_write,
            bus.wb_sel, bus.busy, bus.halted};
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_instr(logic [5:0] op, bit z, bit s, bit c);
    bit ret = 1'b1;
    for (int i = 0; i < ML; i++)
      q.push_back(i == ML - 1 ? (BSY | PCW | IRW) : BSY);
    q.push_back(BSY);
    case (op)
      6'h00: begin q.push_back(BSY | FLW); q.push_back(BSY | RGW); end
      6'h01: begin
        q.push_back(BSY | FLW | IMM);
        q.push_back(BSY | RGW);
      end
      6'h02: begin
        q.push_back(BSY | IMM);
        for (int i = 0; i < ML; i++) q.push_back(BSY | MRD);
        q.push_back(BSY | RGW | WBS);
      end
      6'h03: begin
        q.push_back(BSY | IMM);
        q.push_back(BSY | MWR);
        for (int i = 1; i < ML; i++) q.push_back(BSY);
      end
      6'h04: q.push_back(BSY | PCW | PCS1);
      6'h05: q.push_back(BSY | PCW | PCS2);
      6'h06: q.push_back(BSY | PCW | PCS1 | RGW | LNK);
      6'h08: q.push_back(BSY | PCS1 | (s ? PCW : 13'h0));
      6'h09: q.push_back(BSY | PCS1 | (z ? PCW : 13'h0));
      6'h0A: q.push_back(BSY | PCS1 | (!z ? PCW : 13'h0));
      6'h0B: q.push_back(BSY | PCS1 | (c ? PCW : 13'h0));
      6'h0C: q.push_back(BSY | PCS1 | (!c ? PCW : 13'h0));
      6'h3F: begin q.push_back(HLT); ret = 1'b0; end
      default: begin
`ifdef KGP_ILLEGAL_TRAP_EN
        q.push_back(HLT);
        ret = 1'b0;
`endif
      end
    endcase
    if (ret) exp_ret = (exp_ret + 1) % (1 << RW);
    ret_q.push_back(exp_ret);
  endtask

  task automatic run(string tag, logic [5:0] op, bit z, bit s, bit c);
    int i = 0;
    bus.opcode     = op;
    bus.zero_flag  = z;
    bus.sign_flag  = s;
    bus.carry_flag = c;
    push_instr(op, z, s, c);
    while (q.size() > 0) begin
      @(negedge clk);
      chk($sformatf("%s.c%0d", tag, i), 32'(obs()), 32'(q.pop_front()));
      i++;
      @(posedge clk); #1;
    end
    chk({tag, ".retired"}, 32'(bus.retired), 32'(ret_q.pop_front()));
  endtask

  task automatic kick();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start      = 1'b0;
    bus.opcode     = 6'h00;
    bus.zero_flag  = 1'b0;
    bus.sign_flag  = 1'b0;
    bus.carry_flag = 1'b0;
    #12;
    chk("reset.out", 32'(obs()), 32'h0);
    chk("reset.retired", 32'(bus.retired), 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("idle.out", 32'(obs()), 32'h0);
    kick();

    bus.start = 1'b1;
    foreach (tbl[k])
      run($sformatf("i%0d_op%02h", k, tbl[k].op),
          tbl[k].op, tbl[k].z, tbl[k].s, tbl[k].c);
    bus.start = 1'b0;

    // Abort a store in its first MEM cycle.
    bus.opcode = 6'h03;
    repeat (ML + 2) @(posedge clk);
    #1;
    chk("sw.mem_write", 32'(bus.mem_write), 32'h1);
    rst = 1'b0;
    #1;
    exp_ret = 0;
    chk("abort.out", 32'(obs()), 32'h0);
    chk("abort.retired", 32'(bus.retired), 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("abort.next", 32'(obs()), 32'h0);
    kick();

    run("illegal", 6'h2A, 0, 0, 0);
`ifdef KGP_ILLEGAL_TRAP_EN
    chk("illegal.flag", 32'(bus.illegal), 32'h1);
    @(posedge clk); #1;
    chk("illegal.sticky", 32'(bus.illegal), 32'h1);
    rst = 1'b0;
    #1;
    chk("illegal.clear", 32'(bus.illegal), 32'h0);
    exp_ret = 0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    kick();
`endif
    run("alu", 6'h00, 0, 0, 0);
    run("halt", 6'h3F, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      bus.start = i[0];
      @(posedge clk); #1;
      chk($sformatf("halt.out%0d", i), 32'(obs()), 32'(HLT));
      chk($sformatf("halt.ret%0d", i), 32'(bus.retired), 32'(exp_ret));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
